// File: rtl/finish_retire_tracker_pkg.sv
// Shared TileLink manager definitions for the Finish path (tracker and client-side Finish queue).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package finish_retire_tracker_pkg;

  // Default tag-space geometry for one manager.
  localparam int N_XACT_DEF = 4;
  localparam int XACT_W_DEF = 2;

  // Manager id field of a Finish beat.
  localparam int MGR_ID_W = 1;

  typedef enum logic [MGR_ID_W-1:0] {
    MGR_ID_0 = 1'b0,
    MGR_ID_1 = 1'b1
  } manager_id_e;

  // Finish bundle field widths, shared with the client-side Finish queue.
  localparam int FIN_XACT_W = XACT_W_DEF;
  localparam int FIN_MGR_W  = MGR_ID_W;

  typedef struct packed {
    logic [FIN_XACT_W-1:0] manager_xact_id;
    manager_id_e           manager_id;
  } finish_bits_t;

endpackage

// File: rtl/finish_retire_tracker_if.sv
// Grant-side tag allocation and Finish-side retirement bundle for finish_retire_tracker.
// Latency: n/a (wires only).
// Backpressure: alloc uses valid/ready; finish_ready is high whenever the tracker is out of reset.
//   master: Grant generator / Finish source (drives alloc_valid, finish_*).
//   slave : the tracker (drives alloc_ready/xact_id, busy, count, idle, err_*).
interface finish_retire_tracker_if
  import finish_retire_tracker_pkg::*;
#(
  parameter int N_XACT = N_XACT_DEF,
  parameter int XACT_W = XACT_W_DEF
);

  logic                alloc_valid;
  logic                alloc_ready;
  logic [XACT_W-1:0]   alloc_xact_id;

  logic                finish_valid;
  logic                finish_ready;
  logic [XACT_W-1:0]   finish_bits_manager_xact_id;
  logic [MGR_ID_W-1:0] finish_bits_manager_id;

  logic [N_XACT-1:0]   busy;
  logic [XACT_W:0]     count;
  logic                idle;
  logic                err_valid;
  logic [XACT_W-1:0]   err_xact_id;

  modport master (
    output alloc_valid,
    input  alloc_ready,
    input  alloc_xact_id,
    output finish_valid,
    input  finish_ready,
    output finish_bits_manager_xact_id,
    output finish_bits_manager_id,
    input  busy,
    input  count,
    input  idle,
    input  err_valid,
    input  err_xact_id
  );

  modport slave (
    input  alloc_valid,
    output alloc_ready,
    output alloc_xact_id,
    input  finish_valid,
    output finish_ready,
    input  finish_bits_manager_xact_id,
    input  finish_bits_manager_id,
    output busy,
    output count,
    output idle,
    output err_valid,
    output err_xact_id
  );

endinterface

// File: rtl/finish_retire_tracker_lowest_set_enc.sv
// Priority encoder: index of the lowest set bit of in_vec, plus an any-set flag.
// Latency: combinational.
// Backpressure: none.
//   in_vec : N-bit request vector
//   any    : at least one bit of in_vec is set
//   idx    : lowest set bit position; 0 when nothing is set
module lowest_set_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     in_vec,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    any = |in_vec;
    idx = '0;
    // Scan high to low so the lowest set bit wins the last assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (in_vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/finish_retire_tracker.sv
// Manager-side Finish receiver: hands out manager_xact_id tags for Grants and retires them on Finish.
// Latency: alloc tag returned in the same cycle; Finish captured at edge N, busy cleared / err pulsed at edge N+1.
// Backpressure: alloc_ready drops only when every tag is busy; finish_ready is always high out of reset.
//   clk, reset : rising-edge clock, asynchronous active-high reset (release expected synchronous to clk)
//   io (slave) : alloc handshake, Finish beat, busy/count/idle status, one-cycle err pulse with tag
module finish_retire_tracker
  import finish_retire_tracker_pkg::*;
#(
  parameter int          N_XACT     = N_XACT_DEF,
  parameter int          XACT_W     = XACT_W_DEF,
  parameter manager_id_e MANAGER_ID = MGR_ID_0
) (
  input  logic                    clk,
  input  logic                    reset,
  finish_retire_tracker_if.slave  io
);

  logic [N_XACT-1:0]   busy_q;
  logic [XACT_W:0]     count_q;
  logic                fin_v_q;
  logic [XACT_W-1:0]   fin_id_q;
  logic [MGR_ID_W-1:0] fin_mgr_q;
  logic                err_q;
  logic [XACT_W-1:0]   err_id_q;

  logic                free_any;
  logic [XACT_W-1:0]   free_idx;
  logic                alloc_fire;
  logic                fin_fire;
  logic                retire_ok;
  logic                retire_bad;
  logic [N_XACT-1:0]   busy_set;
  logic [N_XACT-1:0]   busy_clr;

  // Search the free mask; alloc_ready depends only on registered state.
  lowest_set_enc #(
    .N     (N_XACT),
    .IDX_W (XACT_W)
  ) u_free_enc (
    .in_vec (~busy_q),
    .any    (free_any),
    .idx    (free_idx)
  );

  assign alloc_fire = io.alloc_valid & free_any;
  assign fin_fire   = io.finish_valid & io.finish_ready;

  // A staged Finish retires only if it targets this manager and the tag is outstanding.
  assign retire_ok  = fin_v_q & (fin_mgr_q == MANAGER_ID) & busy_q[fin_id_q];
  assign retire_bad = fin_v_q & ~retire_ok;

  // Alloc picks from the pre-edge mask, so it never collides with the tag being retired.
  assign busy_set = {{(N_XACT-1){1'b0}}, alloc_fire} << free_idx;
  assign busy_clr = {{(N_XACT-1){1'b0}}, retire_ok}  << fin_id_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= (busy_q | busy_set) & ~busy_clr;
      count_q <= count_q + (XACT_W+1)'(alloc_fire) - (XACT_W+1)'(retire_ok);
    end
  end

  // Capture stage: one Finish per cycle, no bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fin_v_q   <= 1'b0;
      fin_id_q  <= '0;
      fin_mgr_q <= '0;
    end else begin
      fin_v_q <= fin_fire;
      if (fin_fire) begin
        fin_id_q  <= io.finish_bits_manager_xact_id;
        fin_mgr_q <= io.finish_bits_manager_id;
      end
    end
  end

  // Registered err pulse: a staged Finish wiped by reset never reaches it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      err_q <= retire_bad;
      if (retire_bad) err_id_q <= fin_id_q;
    end
  end

  assign io.alloc_ready   = free_any;
  assign io.alloc_xact_id = free_idx;
  assign io.finish_ready  = ~reset;
  assign io.busy          = busy_q;
  assign io.count         = count_q;
  assign io.idle          = (count_q == '0) & ~fin_v_q;
  assign io.err_valid     = err_q;
  assign io.err_xact_id   = err_id_q;

endmodule

// File: tb/tb_finish_retire_tracker.sv
module tb_finish_retire_tracker;

  logic clk;
  logic reset;

  int checks;
  int errors;

  finish_retire_tracker_if #(.N_XACT(4), .XACT_W(2)) io ();

  finish_retire_tracker dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic       fv;
    logic [1:0] fid;
    logic       fmgr;
    logic       rdy;
    logic [1:0] id;
    logic [3:0] busy;
    logic [2:0] cnt;
    logic       idle;
    logic       err;
    logic [1:0] eid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic av, input logic fv, input logic [1:0] fid, input logic fmgr,
                     input logic rdy, input logic [1:0] id, input logic [3:0] busy,
                     input logic [2:0] cnt, input logic idle, input logic err, input logic [1:0] eid);
    vec_t v;
    v.av = av; v.fv = fv; v.fid = fid; v.fmgr = fmgr;
    v.rdy = rdy; v.id = id; v.busy = busy; v.cnt = cnt;
    v.idle = idle; v.err = err; v.eid = eid;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_quiet_reset(input string tag);
    chk({tag, " busy"},         int'(io.busy), 0);
    chk({tag, " count"},        int'(io.count), 0);
    chk({tag, " idle"},         int'(io.idle), 1);
    chk({tag, " alloc_ready"},  int'(io.alloc_ready), 1);
    chk({tag, " alloc_xact_id"}, int'(io.alloc_xact_id), 0);
    chk({tag, " err_valid"},    int'(io.err_valid), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //  av fv fid mgr | rdy id busy     cnt idle err eid
    add(1, 0, 0, 0,   1, 0, 4'b0000, 0, 1, 0, 0);  // alloc 0
    add(1, 0, 0, 0,   1, 1, 4'b0001, 1, 0, 0, 0);  // alloc 1
    add(1, 0, 0, 0,   1, 2, 4'b0011, 2, 0, 0, 0);  // alloc 2
    add(1, 0, 0, 0,   1, 3, 4'b0111, 3, 0, 0, 0);  // alloc 3
    add(1, 0, 0, 0,   0, 0, 4'b1111, 4, 0, 0, 0);  // full: valid ignored
    add(0, 1, 2, 0,   0, 0, 4'b1111, 4, 0, 0, 0);  // Finish tag 2
    add(0, 0, 0, 0,   0, 0, 4'b1111, 4, 0, 0, 0);  // retire stage
    add(1, 0, 0, 0,   1, 2, 4'b1011, 3, 0, 0, 0);  // tag 2 free again, realloc
    add(0, 1, 1, 0,   0, 0, 4'b1111, 4, 0, 0, 0);  // Finish tag 1
    add(0, 1, 1, 0,   0, 0, 4'b1111, 4, 0, 0, 0);  // duplicate Finish tag 1
    add(0, 0, 0, 0,   1, 1, 4'b1101, 3, 0, 0, 0);  // first retired
    add(0, 0, 0, 0,   1, 1, 4'b1101, 3, 0, 1, 1);  // duplicate flagged
    add(0, 1, 0, 1,   1, 1, 4'b1101, 3, 0, 0, 0);  // misrouted Finish tag 0
    add(0, 0, 0, 0,   1, 1, 4'b1101, 3, 0, 0, 0);
    add(0, 0, 0, 0,   1, 1, 4'b1101, 3, 0, 1, 0);  // misroute flagged, tag 0 kept
    add(0, 1, 2, 0,   1, 1, 4'b1101, 3, 0, 0, 0);  // Finish tag 2
    add(0, 1, 3, 0,   1, 1, 4'b1101, 3, 0, 0, 0);  // Finish tag 3 back-to-back
    add(0, 0, 0, 0,   1, 1, 4'b1001, 2, 0, 0, 0);
    add(1, 0, 0, 0,   1, 1, 4'b0001, 1, 0, 0, 0);  // alloc 1
    add(0, 1, 0, 0,   1, 2, 4'b0011, 2, 0, 0, 0);  // Finish tag 0
    add(1, 0, 0, 0,   1, 2, 4'b0011, 2, 0, 0, 0);  // alloc 2 while tag 0 retires
    add(0, 1, 1, 0,   1, 0, 4'b0110, 2, 0, 0, 0);  // count held at 2; Finish tag 1
    add(0, 0, 0, 0,   1, 0, 4'b0110, 2, 0, 0, 0);
    add(1, 0, 0, 0,   1, 0, 4'b0100, 1, 0, 0, 0);  // alloc 0
    add(0, 1, 1, 0,   1, 1, 4'b0101, 2, 0, 0, 0);  // stray Finish tag 1 left staged

    io.alloc_valid = 1'b0;
    io.finish_valid = 1'b0;
    io.finish_bits_manager_xact_id = '0;
    io.finish_bits_manager_id = '0;
    reset = 1'b1;

    #1;
    chk_quiet_reset("in_reset");
    chk("in_reset finish_ready", int'(io.finish_ready), 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      io.alloc_valid = vecs[i].av;
      io.finish_valid = vecs[i].fv;
      io.finish_bits_manager_xact_id = vecs[i].fid;
      io.finish_bits_manager_id = vecs[i].fmgr;
      @(negedge clk);
      chk($sformatf("v%0d alloc_ready", i),  int'(io.alloc_ready), int'(vecs[i].rdy));
      if (vecs[i].rdy)
        chk($sformatf("v%0d alloc_xact_id", i), int'(io.alloc_xact_id), int'(vecs[i].id));
      chk($sformatf("v%0d busy", i),         int'(io.busy), int'(vecs[i].busy));
      chk($sformatf("v%0d count", i),        int'(io.count), int'(vecs[i].cnt));
      chk($sformatf("v%0d idle", i),         int'(io.idle), int'(vecs[i].idle));
      chk($sformatf("v%0d err_valid", i),    int'(io.err_valid), int'(vecs[i].err));
      if (vecs[i].err)
        chk($sformatf("v%0d err_xact_id", i), int'(io.err_xact_id), int'(vecs[i].eid));
      chk($sformatf("v%0d finish_ready", i), int'(io.finish_ready), 1);
    end

    // Edge captures the stray Finish: fin_v_q=1, busy=0101. Reset mid-cycle.
    @(posedge clk);
    #1;
    io.alloc_valid = 1'b0;
    io.finish_valid = 1'b0;
    chk("pre_reset busy", int'(io.busy), 5);
    chk("pre_reset idle", int'(io.idle), 0);
    #2;
    reset = 1'b1;
    #1;
    chk_quiet_reset("mid_reset");
    chk("mid_reset finish_ready", int'(io.finish_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_quiet_reset($sformatf("post_reset c%0d", c));
      chk($sformatf("post_reset c%0d finish_ready", c), int'(io.finish_ready), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
